// File: rtl/psum_addr_seq_if.sv
// psum_addr_seq_if: bundles the control, beat and scratchpad-address signals
// of the psum address sequencer.
//
// Handshake: psum_valid marks one psum beat in the current cycle. There is
// no backpressure, so a beat is consumed in the same cycle it is presented.
// In READ mode psum_valid means "consumer ready for a read this cycle".
//
// Signals (master = PE-array/controller side, slave = sequencer):
//   start       master->slave  single-cycle start pulse
//   mode        master->slave  00 WRITE, 01 ACCUM, 10 READ, 11 reserved
//   cfg_base    master->slave  first window address
//   cfg_len     master->slave  window entry count, 0 means 2^PSUM_ADDR_LEN
//   psum_valid  master->slave  beat / consumer-ready strobe
//   rd_en       slave->master  scratchpad read strobe
//   rd_addr     slave->master  scratchpad read address
//   wr_en       slave->master  scratchpad write strobe
//   wr_addr     slave->master  scratchpad write address
//   busy        slave->master  high in RUN and DRAIN
//   done        slave->master  one-cycle completion pulse
interface psum_addr_seq_if #(
  parameter int PSUM_ADDR_LEN = 8
);
  logic                     start;
  logic [1:0]               mode;
  logic [PSUM_ADDR_LEN-1:0] cfg_base;
  logic [PSUM_ADDR_LEN-1:0] cfg_len;
  logic                     psum_valid;
  logic                     rd_en;
  logic [PSUM_ADDR_LEN-1:0] rd_addr;
  logic                     wr_en;
  logic [PSUM_ADDR_LEN-1:0] wr_addr;
  logic                     busy;
  logic                     done;

  modport master (
    output start, mode, cfg_base, cfg_len, psum_valid,
    input  rd_en, rd_addr, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  start, mode, cfg_base, cfg_len, psum_valid,
    output rd_en, rd_addr, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/psum_addr_seq.sv
// psum_addr_seq: partial-sum scratchpad address sequencer.
//
// Walks a window [base, base+len) of the psum scratchpad and produces
// separate read and write address/enable streams:
//   WRITE : one write per psum beat (first pass).
//   ACCUM : one read per beat, the matching write RMW_LAT cycles later
//           (read-modify-write accumulate).
//   READ  : one read per consumer-ready beat (drain to the consumer).
// A one-cycle done pulse follows the last access.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        psum_addr_seq_if.slave (start/mode/cfg/psum_valid in,
//              rd/wr enables and addresses, busy, done out)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 FIN)
module psum_addr_seq #(
  parameter int PSUM_ADDR_LEN = 8,
  parameter int RMW_LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_addr_seq_if.slave       bus,
  output logic [1:0]           state_dbg
);

  localparam int N  = PSUM_ADDR_LEN;
  localparam int CW = PSUM_ADDR_LEN + 1;  // one extra bit so len = 2^N fits

  localparam logic [1:0] MODE_WRITE = 2'b00;
  localparam logic [1:0] MODE_ACCUM = 2'b01;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t         state;
  logic [1:0]     mode_q;
  logic [N-1:0]   base_q;
  logic [CW-1:0]  len_q;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  wr_cnt;
  // Read-issue history for ACCUM; bit RMW_LAT-1 is the read issued
  // RMW_LAT cycles ago, i.e. the write due now.
  logic [RMW_LAT-1:0] pipe;

  logic active;
  logic is_accum;
  logic rd_fire;
  logic wr_fire;

  assign active   = (state == RUN) || (state == DRAIN);
  assign is_accum = (mode_q == MODE_ACCUM);

  // Reads are issued only in RUN, for READ and ACCUM.
  assign rd_fire = (state == RUN) && bus.psum_valid && (mode_q != MODE_WRITE);

  // WRITE writes straight off the beat; ACCUM writes come out of the lag
  // pipeline, which keeps emptying through DRAIN.
  assign wr_fire = ((state == RUN) && bus.psum_valid && (mode_q == MODE_WRITE)) ||
                   (active && is_accum && pipe[RMW_LAT-1]);

  assign bus.rd_en   = rd_fire;
  assign bus.wr_en   = wr_fire;
  // Counters and base only move in RUN/DRAIN or on a start, so the
  // addresses naturally hold outside the active states.
  assign bus.rd_addr = base_q + rd_cnt[N-1:0];
  assign bus.wr_addr = base_q + wr_cnt[N-1:0];
  assign bus.busy    = active;
  assign bus.done    = (state == FIN);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= MODE_WRITE;
      base_q <= '0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      pipe   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (bus.mode != MODE_RSVD)) begin
            mode_q <= bus.mode;
            base_q <= bus.cfg_base;
            len_q  <= (bus.cfg_len == '0) ? {1'b1, {N{1'b0}}} : {1'b0, bus.cfg_len};
            rd_cnt <= '0;
            wr_cnt <= '0;
            pipe   <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          pipe <= (pipe << 1) | RMW_LAT'(rd_fire && is_accum);
          if (rd_fire) rd_cnt <= rd_cnt + CW'(1);
          if (wr_fire) wr_cnt <= wr_cnt + CW'(1);
          // Leave RUN on the beat that issues the last entry.
          if (mode_q == MODE_WRITE) begin
            if (wr_fire && (wr_cnt + CW'(1) == len_q)) state <= DRAIN;
          end else begin
            if (rd_fire && (rd_cnt + CW'(1) == len_q)) state <= DRAIN;
          end
        end

        DRAIN: begin
          pipe <= pipe << 1;
          if (wr_fire) wr_cnt <= wr_cnt + CW'(1);
          // ACCUM waits until every lagged write has landed; the check
          // uses the registered count, so exit is the cycle after the
          // final write.
          if (!is_accum || (wr_cnt == len_q)) state <= FIN;
        end

        FIN: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_addr_seq.sv
// Directed testbench for psum_addr_seq. Instance a is N=4, RMW_LAT=2;
// instance b is N=3 and covers the cfg_len=0 (full memory) READ window.
module tb_psum_addr_seq;

  logic       clk;
  logic       rst;
  logic [1:0] st_a;
  logic [1:0] st_b;

  psum_addr_seq_if #(.PSUM_ADDR_LEN(4)) bus_a ();
  psum_addr_seq_if #(.PSUM_ADDR_LEN(3)) bus_b ();

  psum_addr_seq #(.PSUM_ADDR_LEN(4), .RMW_LAT(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a),
    .state_dbg (st_a)
  );

  psum_addr_seq #(.PSUM_ADDR_LEN(3), .RMW_LAT(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_b),
    .state_dbg (st_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks;
  int         errors;
  int         cyc_n;
  string      test_name;
  logic [2:0] exp_q[$];

  // pending start request, applied on the next driven cycle
  logic       s_start;
  logic [1:0] s_mode;
  logic [3:0] s_base;
  logic [3:0] s_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", test_name, tag, obs, exp);
    end
  endtask

  task automatic req_start(input logic [1:0] m, input logic [3:0] b, input logic [3:0] l);
    s_start = 1'b1;
    s_mode  = m;
    s_base  = b;
    s_len   = l;
  endtask

  // One cycle on instance a: drive at negedge, check combinational and
  // registered outputs 1 time unit later. Address -1 means "don't check".
  task automatic cyc(input logic v, input int e_st, input int e_rd, input int e_ra,
                     input int e_wr, input int e_wa, input int e_busy, input int e_done);
    @(negedge clk);
    bus_a.start      = s_start;
    bus_a.mode       = s_mode;
    bus_a.cfg_base   = s_base;
    bus_a.cfg_len    = s_len;
    bus_a.psum_valid = v;
    s_start = 1'b0;
    #1;
    cyc_n++;
    check($sformatf("c%0d state", cyc_n), 32'(st_a), e_st);
    check($sformatf("c%0d rd_en", cyc_n), 32'(bus_a.rd_en), e_rd);
    if (e_ra >= 0) check($sformatf("c%0d rd_addr", cyc_n), 32'(bus_a.rd_addr), e_ra);
    check($sformatf("c%0d wr_en", cyc_n), 32'(bus_a.wr_en), e_wr);
    if (e_wa >= 0) check($sformatf("c%0d wr_addr", cyc_n), 32'(bus_a.wr_addr), e_wa);
    check($sformatf("c%0d busy", cyc_n), 32'(bus_a.busy), e_busy);
    check($sformatf("c%0d done", cyc_n), 32'(bus_a.done), e_done);
  endtask

  task automatic begin_test(input string name);
    test_name = name;
    cyc_n = 0;
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, " state"},   32'(st_a), 0);
    check({tag, " rd_en"},   32'(bus_a.rd_en), 0);
    check({tag, " rd_addr"}, 32'(bus_a.rd_addr), 0);
    check({tag, " wr_en"},   32'(bus_a.wr_en), 0);
    check({tag, " wr_addr"}, 32'(bus_a.wr_addr), 0);
    check({tag, " busy"},    32'(bus_a.busy), 0);
    check({tag, " done"},    32'(bus_a.done), 0);
  endtask

  initial begin
    int n_rd;
    int c_done;
    logic done_seen;

    checks = 0;
    errors = 0;
    s_start = 1'b0; s_mode = 2'b00; s_base = '0; s_len = '0;
    bus_a.start = 1'b0; bus_a.mode = 2'b00; bus_a.cfg_base = '0;
    bus_a.cfg_len = '0; bus_a.psum_valid = 1'b0;
    bus_b.start = 1'b0; bus_b.mode = 2'b00; bus_b.cfg_base = '0;
    bus_b.cfg_len = '0; bus_b.psum_valid = 1'b0;

    // ---------------- reset ----------------
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    begin_test("reset");
    check_all_zero_a("a");
    check("b state", 32'(st_b), 0);
    check("b rd_addr", 32'(bus_b.rd_addr), 0);
    check("b done", 32'(bus_b.done), 0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- WRITE base=3 len=5 ----------------
    begin_test("write");
    req_start(2'b00, 4'd3, 4'd5);
    cyc(0, 0, 0, -1, 0, -1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, -1, 1, 3 + i, 1, 0);
    cyc(1, 2, 0, -1, 0, 8, 1, 0);
    cyc(1, 3, 0, -1, 0, 8, 0, 1);
    cyc(0, 0, 0, -1, 0, 8, 0, 0);

    // ---------------- ACCUM base=14 len=4, wrap ----------------
    begin_test("accum_wrap");
    req_start(2'b01, 4'd14, 4'd4);
    cyc(0, 0, 0, -1, 0, -1, 0, 0);
    cyc(1, 1, 1, 14, 0, 14, 1, 0);
    cyc(1, 1, 1, 15, 0, 14, 1, 0);
    cyc(1, 1, 1, 0,  1, 14, 1, 0);
    cyc(1, 1, 1, 1,  1, 15, 1, 0);
    cyc(1, 2, 0, 2,  1, 0,  1, 0);
    cyc(0, 2, 0, 2,  1, 1,  1, 0);
    cyc(0, 2, 0, 2,  0, 2,  1, 0);
    cyc(0, 3, 0, 2,  0, 2,  0, 1);
    cyc(0, 0, 0, 2,  0, 2,  0, 0);

    // ---------------- ACCUM with gap: valid 1,0,1,1 ----------------
    begin_test("accum_gap");
    req_start(2'b01, 4'd5, 4'd3);
    cyc(0, 0, 0, -1, 0, -1, 0, 0);
    cyc(1, 1, 1, 5, 0, 5, 1, 0);
    cyc(0, 1, 0, 6, 0, 5, 1, 0);
    cyc(1, 1, 1, 6, 1, 5, 1, 0);
    cyc(1, 1, 1, 7, 0, 6, 1, 0);
    cyc(0, 2, 0, 8, 1, 6, 1, 0);
    cyc(0, 2, 0, 8, 1, 7, 1, 0);
    cyc(0, 2, 0, 8, 0, 8, 1, 0);
    cyc(0, 3, 0, 8, 0, 8, 0, 1);
    cyc(0, 0, 0, 8, 0, 8, 0, 0);

    // ---------------- ignored starts ----------------
    begin_test("ignored_start");
    req_start(2'b00, 4'd0, 4'd3);
    cyc(0, 0, 0, -1, 0, -1, 0, 0);
    req_start(2'b10, 4'd9, 4'd1);          // mid-RUN, must be ignored
    cyc(1, 1, 0, 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 1, 2, 1, 0);
    cyc(0, 2, 0, 0, 0, 3, 1, 0);
    req_start(2'b01, 4'd9, 4'd2);          // in FIN, must be ignored
    cyc(0, 3, 0, 0, 0, 3, 0, 1);
    cyc(0, 0, 0, 0, 0, 3, 0, 0);
    req_start(2'b11, 4'd9, 4'd2);          // reserved mode in IDLE
    cyc(0, 0, 0, 0, 0, 3, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 0, 0);

    // ---------------- async reset mid-ACCUM ----------------
    begin_test("reset_mid");
    req_start(2'b01, 4'd2, 4'd4);
    cyc(0, 0, 0, -1, 0, -1, 0, 0);
    cyc(1, 1, 1, 2, 0, 2, 1, 0);
    cyc(1, 1, 1, 3, 0, 2, 1, 0);
    cyc(1, 1, 1, 4, 1, 2, 1, 0);
    cyc(1, 1, 1, 5, 1, 3, 1, 0);           // second write is on the bus now
    #1;
    rst = 1'b0;
    #1;
    check_all_zero_a("async");
    @(posedge clk);
    #1;
    check_all_zero_a("held");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    req_start(2'b01, 4'd6, 4'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 6, 0, 6, 1, 0);
    cyc(1, 2, 0, 7, 0, 6, 1, 0);
    cyc(0, 2, 0, 7, 1, 6, 1, 0);
    cyc(0, 2, 0, 7, 0, 7, 1, 0);
    cyc(0, 3, 0, 7, 0, 7, 0, 1);
    cyc(0, 0, 0, 7, 0, 7, 0, 0);

    // ---------------- N=3 READ, cfg_len=0 -> 8 reads ----------------
    begin_test("read_full");
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(5 + i));
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.mode = 2'b10; bus_b.cfg_base = 3'd5;
    bus_b.cfg_len = 3'd0; bus_b.psum_valid = 1'b0;
    #1;
    check("b idle at start", 32'(st_b), 0);
    n_rd = 0;
    c_done = -1;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      bus_b.psum_valid = 1'b1;
      #1;
      if (bus_b.rd_en) begin
        n_rd++;
        if (exp_q.size() == 0) check("b extra read", 32'(bus_b.rd_en), 0);
        else check($sformatf("b rd_addr %0d", n_rd), 32'(bus_b.rd_addr), 32'(exp_q.pop_front()));
      end
      if (bus_b.wr_en) check("b wr_en", 32'(bus_b.wr_en), 0);
      if (bus_b.done) begin
        done_seen = 1'b1;
        c_done = c;
      end
    end
    bus_b.psum_valid = 1'b0;
    check("b read count", 32'(n_rd), 8);
    check("b done seen", 32'(done_seen), 1);
    check("b done cycle", 32'(c_done), 9);
    check("b queue empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
